mem_access_unit: RTL

//  - MEM-stage load/store unit between the EX/MEM pipeline register and MEM_WB.
//  - Drives a request/acknowledge data-bus port, builds byte enables and store-data lanes,
//    and sign/zero-extends load data.
//  - Produces the write-back value for the MEM_WB din input.
//  - Raises stall_out so the hazard unit holds the pipeline registers (their stop input)

---
 rtl/mem_access_unit.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit with req/ack data bus (optional MISALIGN_TRAP_EN)
module mem_access_unit #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] alu_result,
    output logic        stall_out,
    output logic [31:0] result,
    output logic        misalign,
    output logic        timeout,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [7:0] MAX_W8 = 8'(MAX_WAIT);

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
    logic        misalign_q, misalign_d;

    logic        acc;
    logic [1:0]  size;
    logic [1:0]  eff_off;
    logic        mis_now;
    logic [3:0]  be_now;
    logic [31:0] wdata_now;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;
    logic [7:0]  cnt_inc;

    assign acc  = valid_in & (mem_read | mem_write);
    assign size = funct3[1:0];

`ifdef MISALIGN_TRAP_EN
    assign mis_now = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
    assign eff_off = addr[1:0];
`else
    // Without trapping, halfword/word offsets are silently aligned down.
    assign mis_now = 1'b0;
    assign eff_off = size[1] ? 2'b00 : (size[0] ? {addr[1], 1'b0} : addr[1:0]);
`endif

    always_comb begin
        be_now    = 4'b1111;
        wdata_now = wdata;
        case (size)
            2'b00: begin
                be_now    = 4'b0001 << eff_off;
                wdata_now = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_now    = 4'b0011 << {eff_off[1], 1'b0};
                wdata_now = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_lane = bus_rdata[7:0];
        case (off_q)
            2'b01:   byte_lane = bus_rdata[15:8];
            2'b10:   byte_lane = bus_rdata[23:16];
            2'b11:   byte_lane = bus_rdata[31:24];
            default: ;
        endcase
        half_lane = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (f3_q)
            3'b000:  load_ext = {{24{byte_lane[7]}}, byte_lane};
            3'b100:  load_ext = {24'd0, byte_lane};
            3'b001:  load_ext = {{16{half_lane[15]}}, half_lane};
            3'b101:  load_ext = {16'd0, half_lane};
            default: load_ext = bus_rdata;
        endcase
    end

    assign cnt_inc = (cnt_q == MAX_W8) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        off_d      = off_q;
        f3_d       = f3_q;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
        misalign_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (acc) begin
                    we_d  = mem_write;
                    f3_d  = funct3;
                    off_d = eff_off;
                    if (mis_now) begin
                        state_d    = S_DONE;
                        misalign_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        req_d   = 1'b1;
                        addr_d  = {addr[31:2], 2'b00};
                        be_d    = be_now;
                        wdata_d = wdata_now;
                        cnt_d   = 8'd0;
                    end
                end
            end
            S_WAIT: begin
                if (bus_ack) begin
                    rdata_d = load_ext;
                    req_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == MAX_W8) begin
                        req_d     = 1'b0;
                        timeout_d = 1'b1;
                        state_d   = S_DONE;
                    end
                end
            end
            // The same instruction is still presented here; never relaunch it.
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            be_q       <= 4'd0;
            wdata_q    <= 32'd0;
            off_q      <= 2'd0;
            f3_q       <= 3'd0;
            rdata_q    <= 32'd0;
            cnt_q      <= 8'd0;
            timeout_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            off_q      <= off_d;
            f3_q       <= f3_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
            misalign_q <= misalign_d;
        end
    end

    assign stall_out = ((state_q == S_IDLE) && acc) || (state_q == S_WAIT);
    assign result    = (state_q == S_DONE)
                     ? ((we_q || timeout_q || misalign_q) ? 32'd0 : rdata_q)
                     : alu_result;
    assign misalign  = misalign_q;
    assign timeout   = timeout_q;
    assign bus_req   = req_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;
endmodule
